// File: rtl/cpu_pkg.sv
// Shared types and constants for the SAP-1.5 style CPU.
package cpu_pkg;

    localparam int CPU_ADDR_W = 4;
    localparam int CPU_DATA_W = 8;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_LDB = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_STA = 4'h5,
        OP_LDI = 4'h6,
        OP_JMP = 4'h7,
        OP_JC  = 4'h8,
        OP_JZ  = 4'h9,
        OP_RSA = 4'hA,
        OP_RSB = 4'hB,
        OP_RSC = 4'hC,
        OP_RSD = 4'hD,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    typedef struct packed {
        logic mar_pc;
        logic mar_op;
        logic ir_ld;
        logic pc_inc;
        logic pc_jmp;
        logic a_ram;
        logic a_imm;
        logic a_alu;
        logic b_ram;
        logic ram_we;
        logic out_ld;
        logic hlt;
        logic sub;
        logic last;
    } ctrl_t;

    function automatic step_t next_step(step_t s, logic last);
        step_t n;
        n = T0;
        if (!last) begin
            case (s)
                T0:      n = T1;
                T1:      n = T2;
                T2:      n = T3;
                T3:      n = T4;
                default: n = T0;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/ram_16x8.sv
// Unified program/data RAM: combinational read, synchronous write.
module ram_16x8
    import cpu_pkg::*;
#(
    parameter int AW = CPU_ADDR_W,
    parameter int DW = CPU_DATA_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] ram [0:(1<<AW)-1];

    assign rdata = ram[addr];

    always_ff @(posedge clk) begin
        if (we) ram[addr] <= wdata;
    end

    task dump();
        for (int i = 0; i < (1 << AW); i++)
            $display("ram[%0h] = %02h", i, ram[i]);
    endtask

endmodule

// File: rtl/register_8bit.sv
// Loadable data register with asynchronous active-low clear.
module register_8bit
    import cpu_pkg::*;
#(
    parameter int DW = CPU_DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] latched_data
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    latched_data <= '0;
        else if (load) latched_data <= d;
    end

endmodule

// File: rtl/computer.sv
// SAP-1.5 style microcoded CPU: fetch T0/T1, execute T2..T4.
module computer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] out_val
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    step_t             step;
    logic              carry;
    logic              zero;
    logic              halt;

    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] a_d;
    logic [DATA_W:0]   alu_res;
    logic [ADDR_W-1:0] operand;
    opcode_t           op;
    ctrl_t             cw;

    assign operand = ir[ADDR_W-1:0];
    assign op      = opcode_t'(ir[DATA_W-1:DATA_W-4]);

    always_comb begin
        cw = '0;
        unique case (step)
            T0: cw.mar_pc = 1'b1;
            T1: begin
                cw.ir_ld  = 1'b1;
                cw.pc_inc = 1'b1;
            end
            T2: begin
                cw.last = 1'b1;
                case (op)
                    OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_STA: begin
                        cw.mar_op = 1'b1;
                        cw.last   = 1'b0;
                    end
                    OP_LDI: cw.a_imm  = 1'b1;
                    OP_JMP: cw.pc_jmp = 1'b1;
                    OP_JC:  cw.pc_jmp = carry;
                    OP_JZ:  cw.pc_jmp = zero;
                    OP_OUT: cw.out_ld = 1'b1;
                    OP_HLT: cw.hlt    = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                cw.last = 1'b1;
                case (op)
                    OP_LDA: cw.a_ram  = 1'b1;
                    OP_LDB: cw.b_ram  = 1'b1;
                    OP_STA: cw.ram_we = 1'b1;
                    OP_ADD, OP_SUB: begin
                        cw.b_ram = 1'b1;
                        cw.last  = 1'b0;
                    end
                    default: ;
                endcase
            end
            T4: begin
                cw.a_alu = 1'b1;
                cw.sub   = (op == OP_SUB);
                cw.last  = 1'b1;
            end
            default: cw.last = 1'b1;
        endcase
    end

    // 9-bit result; on SUB the top bit is a borrow, inverted into carry
    always_comb begin
        if (cw.sub) alu_res = {1'b0, a_q} - {1'b0, b_q};
        else        alu_res = {1'b0, a_q} + {1'b0, b_q};
    end

    always_comb begin
        if (cw.a_ram)      a_d = ram_q;
        else if (cw.a_imm) a_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
        else               a_d = alu_res[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= '0;
            mar   <= '0;
            ir    <= '0;
            step  <= T0;
            carry <= 1'b0;
            zero  <= 1'b0;
            halt  <= 1'b0;
        end else if (!halt) begin
            if (cw.mar_pc) mar <= pc;
            if (cw.mar_op) mar <= operand;
            if (cw.ir_ld)  ir  <= ram_q;
            if (cw.pc_inc) pc  <= pc + 1'b1;
            if (cw.pc_jmp) pc  <= operand;
            if (cw.a_alu) begin
                carry <= cw.sub ? ~alu_res[DATA_W] : alu_res[DATA_W];
                zero  <= (alu_res[DATA_W-1:0] == '0);
            end
            if (cw.hlt) halt <= 1'b1;
            step <= next_step(step, cw.last);
        end
    end

    ram_16x8 #(.AW(ADDR_W), .DW(DATA_W)) u_ram (
        .clk   (clk),
        .we    (cw.ram_we && !halt),
        .addr  (mar),
        .wdata (a_q),
        .rdata (ram_q)
    );

    register_8bit #(.DW(DATA_W)) u_register_A (
        .clk          (clk),
        .reset        (reset),
        .load         (!halt && (cw.a_ram || cw.a_imm || cw.a_alu)),
        .d            (a_d),
        .latched_data (a_q)
    );

    register_8bit #(.DW(DATA_W)) u_register_B (
        .clk          (clk),
        .reset        (reset),
        .load         (!halt && cw.b_ram),
        .d            (ram_q),
        .latched_data (b_q)
    );

    register_8bit #(.DW(DATA_W)) u_register_OUT (
        .clk          (clk),
        .reset        (reset),
        .load         (!halt && cw.out_ld),
        .d            (a_q),
        .latched_data (out_val)
    );

endmodule

// File: tb/tb_computer.sv
// Directed program tests for the computer CPU.
module tb_computer;
    import cpu_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] out_val;

    int n_tests = 0;
    int n_fail  = 0;

    computer dut (
        .clk     (clk),
        .reset   (reset),
        .out_val (out_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic prep();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) dut.u_ram.ram[i] = 8'h00;
    endtask

    task automatic poke(input logic [3:0] a, input logic [7:0] v);
        dut.u_ram.ram[a] = v;
    endtask

    task automatic release_rst();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (dut.halt) break;
            @(negedge clk);
        end
        check(tag, dut.halt, 1);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        run_cycles(2);

        // reset state
        check("rst_out", out_val, 0);
        check("rst_a", dut.u_register_A.latched_data, 0);
        check("rst_pc", dut.pc, 0);
        check("rst_ir", dut.ir, 0);
        check("rst_step", dut.step, T0);
        check("rst_halt", dut.halt, 0);

        // LDA
        prep();
        poke(4'h0, 8'h1E); poke(4'h1, 8'hF0); poke(4'hE, 8'hAB);
        release_rst();
        wait_halt("lda_halt", 50);
        check("lda_a", dut.u_register_A.latched_data, 8'hAB);

        // ADD + OUT
        prep();
        poke(4'h0, 8'h1E); poke(4'h1, 8'h3F); poke(4'h2, 8'hE0);
        poke(4'h3, 8'hF0); poke(4'hE, 8'h05); poke(4'hF, 8'h07);
        release_rst();
        wait_halt("add_halt", 50);
        check("add_out", out_val, 8'h0C);
        check("add_c", dut.carry, 0);
        check("add_z", dut.zero, 0);
        check("add_b", dut.u_register_B.latched_data, 8'h07);

        // SUB to zero, no borrow
        prep();
        poke(4'h0, 8'h1E); poke(4'h1, 8'h4E); poke(4'h2, 8'hE0);
        poke(4'h3, 8'hF0); poke(4'hE, 8'h10);
        release_rst();
        wait_halt("sub0_halt", 50);
        check("sub0_a", dut.u_register_A.latched_data, 8'h00);
        check("sub0_z", dut.zero, 1);
        check("sub0_c", dut.carry, 1);

        // SUB with borrow
        prep();
        poke(4'h0, 8'h1E); poke(4'h1, 8'h4F); poke(4'h2, 8'hE0);
        poke(4'h3, 8'hF0); poke(4'hE, 8'h01); poke(4'hF, 8'h02);
        release_rst();
        wait_halt("subb_halt", 50);
        check("subb_a", dut.u_register_A.latched_data, 8'hFF);
        check("subb_c", dut.carry, 0);
        check("subb_z", dut.zero, 0);
        check("subb_out", out_val, 8'hFF);

        // LDI/STA/JMP/LDB/ADD loop back to OUT and HLT
        prep();
        poke(4'h0, 8'h69); poke(4'h1, 8'h5F); poke(4'h2, 8'h75);
        poke(4'h3, 8'hE0); poke(4'h4, 8'hF0); poke(4'h5, 8'h2F);
        poke(4'h6, 8'h3F); poke(4'h7, 8'h73);
        release_rst();
        run_cycles(20);
        check("jmp_nohalt", dut.halt, 0);
        wait_halt("jmp_halt", 60);
        check("sta_mem", dut.u_ram.ram[15], 8'h09);
        check("ldb_b", dut.u_register_B.latched_data, 8'h09);
        check("jmp_out", out_val, 8'h12);
        check("jmp_pc", dut.pc, 4'h5);
        run_cycles(5);
        check("halt_pc", dut.pc, 4'h5);
        check("halt_out", out_val, 8'h12);
        dut.u_ram.dump();

        // JC taken after FF+01
        prep();
        poke(4'h0, 8'h1E); poke(4'h1, 8'h3F); poke(4'h2, 8'h88);
        poke(4'h3, 8'h61); poke(4'h4, 8'hE0); poke(4'h5, 8'hF0);
        poke(4'h8, 8'h62); poke(4'h9, 8'hE0); poke(4'hA, 8'hF0);
        poke(4'hE, 8'hFF); poke(4'hF, 8'h01);
        release_rst();
        wait_halt("jc_halt", 60);
        check("jc_c", dut.carry, 1);
        check("jc_z", dut.zero, 1);
        check("jc_out", out_val, 8'h02);

        // JZ not taken with flags clear
        prep();
        poke(4'h0, 8'h1E); poke(4'h1, 8'h3F); poke(4'h2, 8'h98);
        poke(4'h3, 8'hE0); poke(4'h4, 8'hF0);
        poke(4'h8, 8'h67); poke(4'h9, 8'hE0); poke(4'hA, 8'hF0);
        poke(4'hE, 8'h01); poke(4'hF, 8'h01);
        release_rst();
        wait_halt("jz_halt", 60);
        check("jz_z", dut.zero, 0);
        check("jz_out", out_val, 8'h02);

        // reset pulled low at T3 of LDA
        prep();
        poke(4'h0, 8'h65); poke(4'h1, 8'hE0); poke(4'h2, 8'h1E);
        poke(4'h3, 8'hE0); poke(4'h4, 8'hF0); poke(4'hE, 8'hAB);
        release_rst();
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (dut.step == T3 && dut.ir == 8'h1E) begin
                    found = 1'b1;
                    break;
                end
            end
            check("mid_found", found, 1);
        end
        check("mid_pre_out", out_val, 8'h05);
        reset = 1'b0;
        #1;
        check("mid_out", out_val, 0);
        check("mid_a", dut.u_register_A.latched_data, 0);
        check("mid_pc", dut.pc, 0);
        check("mid_ir", dut.ir, 0);
        check("mid_step", dut.step, T0);
        check("mid_ram0", dut.u_ram.ram[0], 8'h65);
        check("mid_ramE", dut.u_ram.ram[14], 8'hAB);
        release_rst();
        run_cycles(8);
        check("mid_restart", out_val, 8'h05);
        wait_halt("mid_halt", 60);
        check("mid_final", out_val, 8'hAB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
